// File: rtl/tdi_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdi_dispatch_pkg
// Description : Shared definitions for the TDI stream dispatcher.
//               - state_t     : dispatcher FSM states (IDLE / XFER)
//               - channel-count legality bounds
//               - ch_idx_w()  : width of a channel index for a channel count
// Revision    : 1.0 - initial release
// ============================================================================
package tdi_dispatch_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int c_CH_NUM_MIN = 1;
    localparam int c_CH_NUM_MAX = 8;

    // A single channel still needs a 1-bit index so that ports never
    // collapse to zero width.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : tdi_dispatch_pkg
`default_nettype wire

// File: rtl/tdi_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : tdi_rr_select
// Description : Round-robin channel picker. Grants the first requesting
//               channel strictly after last_idx, wrapping from CH_NUM-1 to 0.
//               Purely combinational.
// Ports       : req       in  CH_NUM  request mask (channel eligible)
//               last_idx  in  IDX_W   index of the previously served channel
//               grant     out CH_NUM  one-hot grant (all zero if no request)
//               grant_idx out IDX_W   index of the granted channel
// Revision    : 1.0 - initial release
// ============================================================================
module tdi_rr_select
    import tdi_dispatch_pkg::*;
#(
    parameter int CH_NUM = 2,
    parameter int IDX_W  = ch_idx_w(CH_NUM)
) (
    input  logic [CH_NUM-1:0] req,
    input  logic [IDX_W-1:0]  last_idx,
    output logic [CH_NUM-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    // Two ascending passes: channels above last_idx first, then the
    // wrapped-around channels up to and including last_idx.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if ((grant == '0) && req[i] && (i > int'(last_idx))) begin
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < CH_NUM; i++) begin
            if ((grant == '0) && req[i] && (i <= int'(last_idx))) begin
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end

endmodule : tdi_rr_select
`default_nettype wire

// File: rtl/tdi_stream_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tdi_stream_dispatch
// Description : Dispatches a TDI AXI-Stream to CH_NUM RDMA output channels,
//               either broadcasting every packet to all enabled channels or
//               distributing whole packets round-robin. Data and tlast are
//               fanned out with zero latency; a beat completes only when
//               every targeted channel accepts it in the same cycle.
// Ports       : clk, rst_n            clock, asynchronous active-low reset
//               s_axis_*              source stream (tdata/tvalid/tlast/tready)
//               m_axis_*              per-channel output streams
//               ch_enable             per-channel write-enable mask
//               ch_prog_full          per-channel downstream almost-full
//               bcast_mode            1 = broadcast, 0 = round-robin
//               busy                  high while a packet is in flight
//               pkt_cnt, stall_cnt    statistics (TDI_DISPATCH_STAT_EN only)
// Config      : TDI_DISPATCH_STAT_EN  adds per-channel packet counters and a
//                                     saturating source-stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tdi_stream_dispatch
    import tdi_dispatch_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int CH_NUM = 2,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [CH_NUM*DATA_W-1:0] m_axis_tdata,
    output logic [CH_NUM-1:0]        m_axis_tvalid,
    output logic [CH_NUM-1:0]        m_axis_tlast,
    input  logic [CH_NUM-1:0]        m_axis_tready,
    input  logic [CH_NUM-1:0]        ch_enable,
    input  logic [CH_NUM-1:0]        ch_prog_full,
    input  logic                     bcast_mode,
    output logic                     busy
`ifdef TDI_DISPATCH_STAT_EN
    ,
    output logic [CH_NUM*CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]         stall_cnt
`endif
);

    localparam int IDX_W = ch_idx_w(CH_NUM);

    if ((CH_NUM < c_CH_NUM_MIN) || (CH_NUM > c_CH_NUM_MAX)) begin : g_ch_num_check
        $error("tdi_stream_dispatch: CH_NUM outside legal range 1..8");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [CH_NUM-1:0]  r_target;
    logic [CH_NUM-1:0]  w_target_next;
    logic               r_rr_pkt;
    logic               w_rr_pkt_next;
    logic [IDX_W-1:0]   r_target_idx;
    logic [IDX_W-1:0]   w_target_idx_next;
    logic [IDX_W-1:0]   r_last_ch;

    logic [CH_NUM-1:0]  w_avail;
    logic [CH_NUM-1:0]  w_rr_grant;
    logic [IDX_W-1:0]   w_rr_idx;
    logic [CH_NUM-1:0]  w_tgt_rdy;
    logic               w_xfer;
    logic               w_all_rdy;
    logic               w_beat_done;
    logic               w_pkt_done;

    // A channel can take a new packet only when enabled and not almost full.
    assign w_avail = ch_enable & ~ch_prog_full;

    tdi_rr_select #(
        .CH_NUM (CH_NUM),
        .IDX_W  (IDX_W)
    ) u_rr_select (
        .req       (w_avail),
        .last_idx  (r_last_ch),
        .grant     (w_rr_grant),
        .grant_idx (w_rr_idx)
    );

    // Non-targeted channels are treated as always ready so the AND-reduction
    // only looks at the latched target set.
    assign w_xfer        = (r_state == XFER);
    assign w_tgt_rdy     = m_axis_tready | ~r_target;
    assign w_all_rdy     = &w_tgt_rdy;
    assign w_beat_done   = w_xfer & s_axis_tvalid & w_all_rdy;
    assign w_pkt_done    = w_beat_done & s_axis_tlast;
    assign s_axis_tready = w_xfer & w_all_rdy;
    assign busy          = w_xfer;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        // Own ready is excluded so tvalid never depends on this channel's
        // tready (avoids a combinational valid/ready loop downstream).
        localparam logic [CH_NUM-1:0] c_SELF = CH_NUM'(1) << i;
        assign m_axis_tvalid[i] = w_xfer & s_axis_tvalid & r_target[i] & (&(w_tgt_rdy | c_SELF));
        assign m_axis_tdata[i*DATA_W +: DATA_W] = s_axis_tdata;
        assign m_axis_tlast[i]  = s_axis_tlast;
    end

    always_comb begin
        w_state_next      = r_state;
        w_target_next     = r_target;
        w_rr_pkt_next     = r_rr_pkt;
        w_target_idx_next = r_target_idx;
        case (r_state)
            IDLE: begin
                if (s_axis_tvalid) begin
                    if (bcast_mode) begin
                        // Broadcast waits until every enabled channel has room.
                        if ((ch_enable != '0) && (w_avail == ch_enable)) begin
                            w_state_next  = XFER;
                            w_target_next = ch_enable;
                            w_rr_pkt_next = 1'b0;
                        end
                    end else if (w_rr_grant != '0) begin
                        w_state_next      = XFER;
                        w_target_next     = w_rr_grant;
                        w_rr_pkt_next     = 1'b1;
                        w_target_idx_next = w_rr_idx;
                    end
                end
            end
            XFER: begin
                if (w_pkt_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_target     <= '0;
            r_rr_pkt     <= 1'b0;
            r_target_idx <= '0;
            r_last_ch    <= IDX_W'(CH_NUM - 1);
        end else begin
            r_state      <= w_state_next;
            r_target     <= w_target_next;
            r_rr_pkt     <= w_rr_pkt_next;
            r_target_idx <= w_target_idx_next;
            // Only round-robin packets advance the rotation pointer.
            if (w_pkt_done && r_rr_pkt) begin
                r_last_ch <= r_target_idx;
            end
        end
    end

`ifdef TDI_DISPATCH_STAT_EN
    for (genvar i = 0; i < CH_NUM; i++) begin : g_pkt_cnt
        logic [CNT_W-1:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_pkt_done && r_target[i]) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
        assign pkt_cnt[i*CNT_W +: CNT_W] = r_cnt;
    end

    logic [CNT_W-1:0] r_stall_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_xfer && s_axis_tvalid && !s_axis_tready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end
    assign stall_cnt = r_stall_cnt;
`endif

endmodule : tdi_stream_dispatch
`default_nettype wire

// File: tb/tb_tdi_stream_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdi_stream_dispatch
// Description : Self-checking bench for tdi_stream_dispatch (4 channels,
//               32-bit data). A packet-level model predicts busy, tready and
//               per-channel tvalid every cycle; directed scenarios pin the
//               packet routing with literal expectations, then a randomized
//               phase exercises modes, masks and backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdi_stream_dispatch;

    localparam int DW      = 32;
    localparam int CH      = 4;
    localparam int TIMEOUT = 300;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   s_axis_tdata = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tlast = 1'b0;
    logic            s_axis_tready;
    logic [CH*DW-1:0] m_axis_tdata;
    logic [CH-1:0]   m_axis_tvalid;
    logic [CH-1:0]   m_axis_tlast;
    logic [CH-1:0]   m_axis_tready = '1;
    logic [CH-1:0]   ch_enable = '0;
    logic [CH-1:0]   ch_prog_full = '0;
    logic            bcast_mode = 1'b0;
    logic            busy;

    int checks = 0;
    int failures = 0;

    // packet-level reference model
    logic            md_in;
    logic [CH-1:0]   md_tgt;
    logic            md_rr;
    int              md_tch;
    int              md_last;
    int              md_beats[CH];
    logic [CH-1:0]   ev;
    logic            all_rdy;
    logic            ok;
    int              pick;

    // observations of the DUT
    int              dut_beats[CH];
    int              dut_log[$];
    logic [CH-1:0]   seen_v;
    int              stall_seen;

    int              b0, b1, wn;
    logic            rand_on;

    tdi_stream_dispatch #(
        .DATA_W (DW),
        .CH_NUM (CH),
        .CNT_W  (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .ch_enable     (ch_enable),
        .ch_prog_full  (ch_prog_full),
        .bcast_mode    (bcast_mode),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_log(input string nm, input int n, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        check({nm, "_len"}, 64'(dut_log.size()), 64'(n));
        for (int i = 0; i < n && i < 4; i++) begin
            if (i < dut_log.size()) check({nm, "_ch"}, 64'(dut_log[i]), 64'(e[i]));
        end
    endtask

    // Model + monitor: evaluated at the falling edge, where inputs are stable.
    initial begin
        md_in = 1'b0; md_tgt = '0; md_rr = 1'b0; md_tch = 0; md_last = CH - 1;
        seen_v = '0; stall_seen = 0;
        for (int c = 0; c < CH; c++) begin
            md_beats[c] = 0;
            dut_beats[c] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                md_in = 1'b0; md_tgt = '0; md_last = CH - 1;
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_s_tready", 64'(s_axis_tready), 64'(0));
                check("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
            end else begin
                all_rdy = 1'b1;
                for (int c = 0; c < CH; c++)
                    if (md_tgt[c] && !m_axis_tready[c]) all_rdy = 1'b0;
                ev = '0;
                if (md_in && s_axis_tvalid) begin
                    for (int c = 0; c < CH; c++) begin
                        ok = md_tgt[c];
                        for (int k = 0; k < CH; k++)
                            if (k != c && md_tgt[k] && !m_axis_tready[k]) ok = 1'b0;
                        ev[c] = ok;
                    end
                end
                check("busy", 64'(busy), 64'(md_in));
                check("s_tready", 64'(s_axis_tready), 64'(md_in && all_rdy));
                check("m_tvalid", 64'(m_axis_tvalid), 64'(ev));
                for (int c = 0; c < CH; c++) begin
                    if (m_axis_tvalid[c]) seen_v[c] = 1'b1;
                    if (m_axis_tvalid[c] && m_axis_tready[c]) begin
                        check("m_tdata", 64'(m_axis_tdata[c*DW +: DW]), 64'(s_axis_tdata));
                        check("m_tlast", 64'(m_axis_tlast[c]), 64'(s_axis_tlast));
                        dut_beats[c]++;
                        if (m_axis_tlast[c]) dut_log.push_back(c);
                    end
                end
                if (busy && s_axis_tvalid && !s_axis_tready) stall_seen++;

                // advance the model to what the coming rising edge must do
                if (!md_in) begin
                    if (s_axis_tvalid) begin
                        if (bcast_mode) begin
                            if (ch_enable != '0 && (ch_enable & ~ch_prog_full) == ch_enable) begin
                                md_in = 1'b1; md_tgt = ch_enable; md_rr = 1'b0;
                            end
                        end else begin
                            for (int k = 1; k <= CH; k++) begin
                                pick = (md_last + k) % CH;
                                if (!md_in && ch_enable[pick] && !ch_prog_full[pick]) begin
                                    md_in = 1'b1; md_tgt = '0; md_tgt[pick] = 1'b1;
                                    md_rr = 1'b1; md_tch = pick;
                                end
                            end
                        end
                    end
                end else if (s_axis_tvalid && all_rdy) begin
                    for (int c = 0; c < CH; c++)
                        if (md_tgt[c]) md_beats[c]++;
                    if (s_axis_tlast) begin
                        md_in = 1'b0;
                        if (md_rr) md_last = md_tch;
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic last, input int bubble_pct);
        logic took;
        int n;
        while (bubble_pct > 0 && $urandom_range(99, 0) < bubble_pct) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = last;
        took = 1'b0; n = 0;
        while (!took && n < TIMEOUT) begin
            @(negedge clk);
            took = s_axis_tready;
            @(posedge clk); #1;
            n++;
        end
        if (!took) begin
            checks++; failures++;
            $display("FAIL beat_timeout actual=no_handshake expected=handshake at %0t", $time);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int nb, input int bubble_pct);
        for (int b = 0; b < nb; b++)
            send_beat($urandom, (b == nb - 1), bubble_pct);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rand_on = 1'b0;
        apply_reset();

        // A: round-robin over two enabled channels, 4 packets of 3 beats
        bcast_mode = 1'b0; ch_enable = 4'b0011; dut_log.delete();
        b0 = md_beats[0]; b1 = md_beats[1];
        repeat (4) send_pkt(3, 0);
        check_log("A_order", 4, 0, 1, 0, 1);
        check("A_model_ch0", 64'(md_beats[0] - b0), 64'(6));
        check("A_model_ch1", 64'(md_beats[1] - b1), 64'(6));

        // B: sparse mask 1010
        apply_reset();
        ch_enable = 4'b1010; dut_log.delete(); seen_v = '0;
        repeat (3) send_pkt(2, 0);
        check_log("B_order", 3, 1, 3, 1, 0);
        check("B_ch0_ch2_never", 64'(seen_v & 4'b0101), 64'(0));

        // C: broadcast, ch1 stalls for 5 cycles mid-packet
        apply_reset();
        bcast_mode = 1'b1; ch_enable = 4'b0011; dut_log.delete();
        b0 = dut_beats[0]; b1 = dut_beats[1]; stall_seen = 0;
        fork
            send_pkt(4, 0);
            begin
                wn = 0;
                while (dut_beats[0] < b0 + 1 && wn < 100) begin @(posedge clk); wn++; end
                #1 m_axis_tready[1] = 1'b0;
                repeat (5) @(posedge clk);
                #1 m_axis_tready[1] = 1'b1;
            end
        join
        check("C_stall_cycles", 64'(stall_seen), 64'(5));
        check_log("C_both", 2, 0, 1, 0, 0);
        check("C_ch0_beats", 64'(dut_beats[0] - b0), 64'(4));
        check("C_ch1_beats", 64'(dut_beats[1] - b1), 64'(4));

        // D: broadcast held off by prog_full on ch0
        ch_prog_full = 4'b0001; dut_log.delete();
        fork
            send_pkt(2, 0);
            begin
                repeat (6) @(posedge clk);
                #1;
                check("D_idle_busy", 64'(busy), 64'(0));
                check("D_idle_model", 64'(md_in), 64'(0));
                ch_prog_full = 4'b0000;
            end
        join
        check_log("D_both", 2, 0, 1, 0, 0);

        // E: enable mask shrinks mid-packet
        apply_reset();
        bcast_mode = 1'b0; ch_enable = 4'b0011; dut_log.delete();
        send_pkt(2, 0);
        b1 = dut_beats[1];
        fork
            send_pkt(3, 0);
            begin
                wn = 0;
                while (dut_beats[1] < b1 + 1 && wn < 100) begin @(posedge clk); wn++; end
                #1 ch_enable = 4'b0001;
            end
        join
        send_pkt(2, 0);
        check_log("E_order", 3, 0, 1, 0, 0);
        check("E_ch1_beats", 64'(dut_beats[1] - b1), 64'(3));
        ch_enable = 4'b0011;

        // F: reset in the middle of a 4-beat packet
        apply_reset();
        send_pkt(1, 0);
        send_beat(32'hF00D_0001, 1'b0, 0);
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'hF00D_0002; s_axis_tlast = 1'b0;
        #1 check("F_pre_rst_tvalid", 64'(m_axis_tvalid), 64'(4'b0010));
        #1 rst_n = 1'b0;
        #1;
        check("F_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        check("F_rst_tready", 64'(s_axis_tready), 64'(0));
        check("F_rst_busy", 64'(busy), 64'(0));
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        dut_log.delete();
        send_pkt(2, 0);
        check_log("F_restart", 1, 0, 0, 0, 0);

        // Randomized phase
        apply_reset();
        rand_on = 1'b1;
        fork
            begin
                repeat (40) send_pkt($urandom_range(5, 1), 20);
                rand_on = 1'b0;
            end
            while (rand_on) begin
                @(posedge clk); #1;
                m_axis_tready = CH'($urandom) | CH'($urandom);
                ch_prog_full  = CH'($urandom & $urandom & $urandom);
                if ($urandom_range(15, 0) == 0) ch_enable = CH'($urandom);
                if ($urandom_range(15, 0) == 0) bcast_mode = ~bcast_mode;
            end
        join
        m_axis_tready = '1; ch_prog_full = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++)
            check("total_beats", 64'(dut_beats[c]), 64'(md_beats[c]));
        check("end_idle", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tdi_stream_dispatch
`default_nettype wire

// File: doc/tdi_stream_dispatch.md
TDI_STREAM_DISPATCH -- requirements
Module: tdi_stream_dispatch

Interface
REQ-001 SHALL have parameter DATA_W, default 512, the AXIS data width in bits.
REQ-002 SHALL have parameter CH_NUM, default 2, the number of RDMA output channels; legal range 1..8.
REQ-003 SHALL have parameter CNT_W, default 32, the statistics counter width.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port s_axis_tdata/tvalid/tlast  in  DATA_W/1/1  TDI source stream.
REQ-007 SHALL have port s_axis_tready  out  1  source backpressure.
REQ-008 SHALL have port m_axis_tdata/tvalid/tlast  out  CH_NUM*DATA_W/CH_NUM/CH_NUM  per-channel outputs.
REQ-009 SHALL have port m_axis_tready  in  CH_NUM  per-channel ready.
REQ-010 SHALL have port ch_enable  in  CH_NUM  per-channel db_write_enable mask.
REQ-011 SHALL have port ch_prog_full  in  CH_NUM  per-channel downstream FIFO almost-full.
REQ-012 SHALL have port bcast_mode  in  1  select: 1 = broadcast, 0 = round-robin per packet.
REQ-013 SHALL have port busy  out  1  high while a packet is in flight.

Function
REQ-014 SHALL use FSM states IDLE and XFER; a packet is the set of beats up to and including the beat with tlast.
REQ-015 In IDLE with s_axis_tvalid=1, SHALL latch a target mask and enter XFER on the next cycle; s_axis_tready SHALL be 0 in IDLE.
REQ-016 In broadcast mode, target = ch_enable & ~ch_prog_full, and the FSM SHALL leave IDLE only when target == ch_enable != 0.
REQ-017 In round-robin mode, target = the one-hot first channel after last_ch (wrapping at CH_NUM-1 to 0) with ch_enable=1 and ch_prog_full=0; if there is none, SHALL stay in IDLE.
REQ-018 If ch_enable == 0, SHALL stay in IDLE indefinitely and accept no data.
REQ-019 In XFER: m_axis_tvalid[i] = s_axis_tvalid & target[i] & (AND of m_axis_tready over target excluding i); s_axis_tready = AND of m_axis_tready over target; tdata/tlast SHALL be fanned out combinationally, zero latency.
REQ-020 A beat SHALL complete only when all targeted channels accept it in the same cycle.
REQ-021 On a completed tlast beat, SHALL return to IDLE; last_ch SHALL update to the round-robin target; the next packet SHALL be evaluated no earlier than the following cycle.
REQ-022 bcast_mode, ch_enable and ch_prog_full SHALL be ignored during XFER (the packet always completes on its latched target).
REQ-023 busy SHALL equal (state == XFER).

Reset
REQ-024 On rst_n low: state = IDLE, target = 0, last_ch = CH_NUM-1 (so the first RR packet goes to channel 0), all m_axis_tvalid = 0, s_axis_tready = 0, busy = 0, counters = 0.
REQ-025 Reset asserted mid-packet SHALL abandon the packet with no further output beats; upstream resynchronisation is the source's responsibility.

Configuration
REQ-026 Macro TDI_DISPATCH_STAT_EN defined: SHALL add output pkt_cnt (CH_NUM*CNT_W), incrementing per channel on each completed tlast beat and wrapping at 2^CNT_W, plus output stall_cnt (CNT_W), incrementing each XFER cycle with s_axis_tvalid=1 and s_axis_tready=0, saturating.
REQ-027 Macro undefined: these ports and their counters SHALL be absent, with no other behavioural difference.

Structure
REQ-028 Package tdi_dispatch_pkg SHALL hold the state enum, the CH_NUM legality bounds and the channel-index width function.
REQ-029 Round-robin selection SHALL be implemented in sub-module tdi_rr_select (inputs: request mask, last index; output: one-hot grant, grant index).

Verification
REQ-030 CH_NUM=2, RR, enable=2'b11, 4 packets of 3 beats -> packets land on ch0, ch1, ch0, ch1; each channel receives 6 beats in order.
REQ-031 CH_NUM=4, RR, enable=4'b1010 -> packets go to ch1, ch3, ch1; ch0 and ch2 m_axis_tvalid never assert.
REQ-032 Broadcast, CH_NUM=2, ch1 tready low for 5 cycles mid-packet -> neither channel advances, s_axis_tready=0 for exactly those 5 cycles, identical data on both channels.
REQ-033 Broadcast, ch_prog_full=2'b01 at packet start -> stays in IDLE until prog_full clears; then the packet goes to both channels.
REQ-034 ch_enable changed from 2'b11 to 2'b01 mid-packet -> the current packet completes on its latched target; the next packet honours the new mask.
REQ-035 rst_n pulsed low at beat 2 of 4 -> all outputs reach their reset values immediately; the next packet starts at ch0 (RR).
